// File: rtl/niosii_subsys_led_fx_pkg.sv
// Shared definitions for the LED effects stage: register map, per-LED mode
// encodings and the per-LED effect selector.
package niosii_subsys_led_fx_pkg;

   localparam logic [1:0] ADDR_MODE      = 2'd0;
   localparam logic [1:0] ADDR_DUTY      = 2'd1;
   localparam logic [1:0] ADDR_BLINK_DIV = 2'd2;
   localparam logic [1:0] ADDR_STATUS    = 2'd3;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_BLINK = 2'b01,
      MODE_DIM   = 2'b10,
      MODE_OFF   = 2'b11
   } led_mode_e;

   function automatic logic led_fx_sel(
      input logic [1:0] mode,
      input logic       req,
      input logic       blink_phase,
      input logic       pwm_on
   );
      logic drive;
      case (led_mode_e'(mode))
         MODE_PASS:  drive = req;
         MODE_BLINK: drive = req & blink_phase;
         MODE_DIM:   drive = req & pwm_on;
         MODE_OFF:   drive = 1'b0;
         default:    drive = 1'b0;
      endcase
      return drive;
   endfunction

endpackage

// File: rtl/niosii_subsys_led_fx_timebase.sv
// PWM counter and blink divider shared by all LEDs.
// Divisor changes apply at the next compare without disturbing the running count.
module niosii_subsys_led_fx_timebase
   import niosii_subsys_led_fx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  duty,
   input  logic [23:0] blink_div,
   output logic        pwm_on,
   output logic        blink_phase,
   output logic [7:0]  pwm_cnt
);

   logic [7:0]  pwm_cnt_r;
   logic [23:0] blink_cnt_r;
   logic        blink_phase_r;
   logic [23:0] blink_limit_s;
   logic        blink_wrap_s;

   // Terminal count; a zero divisor behaves as one so the phase toggles every cycle.
   always_comb begin
      blink_limit_s = 24'd0;
      blink_wrap_s  = 1'b0;
      if (blink_div == 24'd0) begin
         blink_limit_s = 24'd0;
      end else begin
         blink_limit_s = blink_div - 24'd1;
      end
      // >= rather than == so a divisor shrunk below the count still wraps
      blink_wrap_s = (blink_cnt_r >= blink_limit_s);
   end

   // Free-running PWM ramp, wraps 255 -> 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_r <= 8'd0;
      end else begin
         pwm_cnt_r <= pwm_cnt_r + 8'd1;
      end
   end

   // Blink half-period counter and phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_r   <= 24'd0;
         blink_phase_r <= 1'b0;
      end else if (blink_wrap_s) begin
         blink_cnt_r   <= 24'd0;
         blink_phase_r <= ~blink_phase_r;
      end else begin
         blink_cnt_r   <= blink_cnt_r + 24'd1;
      end
   end

   assign pwm_on      = (pwm_cnt_r < duty);
   assign blink_phase = blink_phase_r;
   assign pwm_cnt     = pwm_cnt_r;

endmodule

// File: rtl/niosii_subsys_led_fx.sv
// LED effects stage between the LED PIO and the board pins: Avalon-MM register
// file, per-LED effect mux and registered pin drive.
module niosii_subsys_led_fx
   import niosii_subsys_led_fx_pkg::*;
#(
   parameter logic [23:0] BLINK_DIV_RESET = 24'd12_500_000,
   parameter logic [7:0]  DUTY_RESET      = 8'h80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  led_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  led_out
);

   logic [15:0] mode_r;
   logic [7:0]  duty_r;
   logic [23:0] blink_div_r;
   logic [7:0]  led_out_r;

   logic        wr_en_s;
   logic        pwm_on_s;
   logic        blink_phase_s;
   logic [7:0]  pwm_cnt_s;
   logic [7:0]  led_next_s;
   logic [31:0] readdata_s;

   assign wr_en_s = chipselect & ~write_n;

   niosii_subsys_led_fx_timebase u_timebase (
      .clk         (clk),
      .reset       (reset),
      .duty        (duty_r),
      .blink_div   (blink_div_r),
      .pwm_on      (pwm_on_s),
      .blink_phase (blink_phase_s),
      .pwm_cnt     (pwm_cnt_s)
   );

   // Control register file; STATUS is read-only so writes to it fall through.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_r      <= 16'd0;
         duty_r      <= DUTY_RESET;
         blink_div_r <= BLINK_DIV_RESET;
      end else if (wr_en_s) begin
         case (address)
            ADDR_MODE:      mode_r      <= writedata[15:0];
            ADDR_DUTY:      duty_r      <= writedata[7:0];
            ADDR_BLINK_DIV: blink_div_r <= writedata[23:0];
            ADDR_STATUS:    ;
            default:        ;
         endcase
      end
   end

   // Per-LED effect selection.
   always_comb begin
      led_next_s = 8'd0;
      for (int i = 0; i < 8; i++) begin
         led_next_s[i] = led_fx_sel(mode_r[2*i +: 2], led_in[i], blink_phase_s, pwm_on_s);
      end
   end

   // Registered pin drive.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_out_r <= 8'd0;
      end else begin
         led_out_r <= led_next_s;
      end
   end

   // Zero-wait-state read mux over current register values.
   always_comb begin
      readdata_s = 32'd0;
      case (address)
         ADDR_MODE:      readdata_s = {16'd0, mode_r};
         ADDR_DUTY:      readdata_s = {24'd0, duty_r};
         ADDR_BLINK_DIV: readdata_s = {8'd0, blink_div_r};
         ADDR_STATUS:    readdata_s = {16'd0, pwm_cnt_s, 7'd0, blink_phase_s};
         default:        readdata_s = 32'd0;
      endcase
   end

   assign readdata = readdata_s;
   assign led_out  = led_out_r;

endmodule

// File: doc/niosii_subsys_led_fx.md
# niosii_subsys_led_fx

Downstream stage of the Nios II subsystem LED PIO. It consumes the PIO's 8-bit `out_port` word as per-LED on/off requests and drives the board LEDs. A small Avalon-MM slave selects one of four effects per LED: pass-through, blink, PWM dim, or forced off. The block sits between the LED PIO and the top-level LED pins, on the same Avalon-MM bus and clock as the PIO.

## Interface

Parameters:
- `BLINK_DIV_RESET`, default 24'd12_500_000: reset value of BLINK_DIV (250 ms half-period at 50 MHz).
- `DUTY_RESET`, default 8'h80: reset value of DUTY.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `led_in`  in  8  LED request word from the PIO `out_port`.
- `address`  in  2  Avalon-MM word address.
- `chipselect`  in  1  Avalon-MM select.
- `write_n`  in  1  Avalon-MM write strobe, active low.
- `writedata`  in  32  Avalon-MM write data.
- `readdata`  out  32  Avalon-MM read data; combinational, zero wait states.
- `led_out`  out  8  LED pin drive, registered.

## Operation

Register map. A write is accepted on a cycle where `chipselect && !write_n`. Unused write bits are ignored; unused read bits return 0.
- 0x0 MODE[15:0]: 2 bits per LED; LED i uses bits [2i+1:2i].
  - 00 PASS: drive `led_in[i]`.
  - 01 BLINK: drive `led_in[i] & blink_phase`.
  - 10 DIM: drive `led_in[i] & pwm_on`.
  - 11 OFF: drive 0.
  - Reset value 0.
- 0x1 DUTY[7:0]: PWM duty. Reset value `DUTY_RESET`.
- 0x2 BLINK_DIV[23:0]: blink half-period in clk cycles. Reset value `BLINK_DIV_RESET`.
- 0x3 STATUS, read-only:
  - bit0 = `blink_phase`.
  - bits[15:8] = `pwm_cnt`.
  - Writes to 0x3 have no effect.

Timebase:
- `pwm_cnt`: 8-bit free-running counter, wraps 255→0.
- `pwm_on = (pwm_cnt < DUTY)`.
  - DUTY=0: always off.
  - DUTY=255: on 255 of every 256 cycles.
- `blink_cnt`: 24-bit counter.
  - When `blink_cnt >= eff_div - 1`: `blink_cnt` ← 0 and `blink_phase` toggles.
  - Otherwise `blink_cnt` increments.
  - `eff_div = max(BLINK_DIV, 1)`, so BLINK_DIV=0 behaves as 1 (toggle every cycle).
  - Writing a BLINK_DIV smaller than the current `blink_cnt` forces a toggle on the next cycle; there is no lock-up.

Reset:
- `led_out`, MODE, `pwm_cnt`, `blink_cnt` and `blink_phase` all clear to 0.
- DUTY and BLINK_DIV load their parameter values.
- A reset asserted mid-period abandons the period. Counting restarts from 0 on the first cycle after `reset` deasserts.

## Timing

- `led_out` is registered: `led_out(t+1) = f(led_in(t), MODE(t), blink_phase(t), pwm_on(t))`.
- Latency from `led_in` to the pins is 1 cycle.
- A register write at edge t affects `led_out` at edge t+1 (1-cycle latency from write to effect).
- `readdata` is combinational from `address` and the current register values.
  - A read in the same cycle as a write returns the old value.
- Write and timebase update in the same cycle:
  - A DUTY write takes effect on the next compare.
  - A BLINK_DIV write takes effect on the next compare; the `blink_cnt` value is not disturbed.
- No handshake beyond Avalon: no waitrequest and no read latency.

## Structure

Shared package/include `niosii_subsys_led_fx_pkg` holds:
- the register addresses (`ADDR_MODE=0`, `ADDR_DUTY=1`, `ADDR_BLINK_DIV=2`, `ADDR_STATUS=3`);
- the mode encodings (`MODE_PASS=2'b00`, `MODE_BLINK=2'b01`, `MODE_DIM=2'b10`, `MODE_OFF=2'b11`).

One sub-module, `niosii_subsys_led_fx_timebase`:
- contains `pwm_cnt`, the blink divider and `blink_phase`;
- inputs: `clk`, `reset`, `duty`, `blink_div`;
- outputs: `pwm_on`, `blink_phase`, `pwm_cnt`.

The parent holds the register file, the per-LED mode mux and the output register.

## Test plan

- **Reset:** hold `reset` for 3 cycles with `led_in`=8'hFF → `led_out`=0 during reset. Readback gives MODE=0, DUTY=8'h80, BLINK_DIV=`BLINK_DIV_RESET`. One cycle after release, `led_out`=8'hFF (PASS).
- **Blink:** MODE=16'h0001, BLINK_DIV=4, `led_in`=8'h01 → `led_out[0]` has a period of 8 cycles, 4 high and 4 low; all other bits follow `led_in` (0).
- **PWM:** MODE=16'h0002, `led_in`=8'h01, sweep DUTY:
  - DUTY=0 → 0 high cycles in 256.
  - DUTY=64 → 64 high cycles in 256.
  - DUTY=255 → 255 high cycles in 256.
- **OFF and mixed modes:** MODE=16'hC000 with `led_in`=8'hFF → `led_out`=8'h7F, one cycle after the write.
- **Boundaries:**
  - BLINK_DIV=0 → `blink_phase` toggles every cycle.
  - With `blink_cnt` at 100, write BLINK_DIV=10 → toggle on the next cycle, then every 10 cycles.
  - Write to 0x3 → STATUS and all other registers unchanged.
- **Reset mid-operation:** assert `reset` in the middle of a blink half-period → `blink_phase`=0 and `pwm_cnt`=0 on release. STATUS reads 0 on the first cycle after release.
